// File: rtl/dsss_despreader.sv
// DSSS despreader: carrier multiply/integrate to hard chips, m-sequence acquisition and tracking.
// Bit latency 2 cycles after the last sample of a period; never stalls, no backpressure.
module dsss_despreader #(
    parameter int SPC      = 1,
    parameter int THRESH   = 13,
    parameter int MISS_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    input  logic [15:0] ref_data,
    output logic        chip_valid,
    output logic        chip_out,
    output logic        locked,
    output logic        bit_valid,
    output logic        bit_out,
    output logic [3:0]  corr
);

    // Bit i of the window holds the chip aligned to c(14-i): MSB is c0, LSB is c14.
    localparam logic [14:0] PATTERN = 15'b111101011001000;
    localparam logic [3:0]  HI      = 4'(THRESH);
    localparam logic [3:0]  LO      = 4'(15 - THRESH);

    typedef enum logic {SEARCH, TRACK} state_t;

    logic signed [15:0] rx_s;
    logic signed [15:0] ref_s;
    logic signed [31:0] prod;
    logic signed [37:0] acc;
    logic signed [37:0] acc_sum;
    logic [6:0]         scnt;

    assign rx_s    = rx_data ^ 16'h8000;
    assign ref_s   = ref_data ^ 16'h8000;
    assign prod    = 32'(rx_s) * 32'(ref_s);
    assign acc_sum = acc + {{6{prod[31]}}, prod};

    // A drop to SEARCH lands one cycle after a chip boundary, when the
    // accumulator has just restarted, so no extra clear is needed here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc        <= '0;
            scnt       <= '0;
            chip_valid <= 1'b0;
            chip_out   <= 1'b0;
        end else begin
            chip_valid <= 1'b0;
            if (rx_valid) begin
                if (scnt == 7'(SPC - 1)) begin
                    chip_valid <= 1'b1;
                    chip_out   <= acc_sum[37];
                    acc        <= '0;
                    scnt       <= '0;
                end else begin
                    acc  <= acc_sum;
                    scnt <= scnt + 7'd1;
                end
            end
        end
    end

    state_t      state;
    logic [14:0] window;
    logic [14:0] win_next;
    logic [3:0]  fill;
    logic [3:0]  lfsr;
    logic [3:0]  idx;
    logic [3:0]  mcnt;
    logic [7:0]  miss;
    logic [3:0]  m_search;
    logic [3:0]  m_track;
    logic        search_hit;
    logic        track_amb;

    assign win_next   = {window[13:0], chip_out};
    assign m_track    = mcnt + {3'b000, chip_out == lfsr[3]};
    assign search_hit = (m_search >= HI) || (m_search <= LO);
    assign track_amb  = (m_track > LO) && (m_track < HI);

    always_comb begin
        m_search = 4'd0;
        for (int i = 0; i < 15; i++) begin
            m_search = m_search + {3'b000, ~(win_next[i] ^ PATTERN[i])};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            window    <= '0;
            fill      <= '0;
            lfsr      <= 4'b1111;
            idx       <= '0;
            mcnt      <= '0;
            miss      <= '0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            corr      <= '0;
        end else begin
            bit_valid <= 1'b0;
            if (chip_valid) begin
                window <= win_next;
                if (fill != 4'd15) fill <= fill + 4'd1;
                case (state)
                    SEARCH: begin
                        if (fill >= 4'd14 && search_hit) begin
                            bit_valid <= 1'b1;
                            bit_out   <= (m_search < 4'd8);
                            corr      <= m_search;
                            lfsr      <= 4'b1111;
                            idx       <= '0;
                            mcnt      <= '0;
                            miss      <= '0;
                            state     <= TRACK;
                            locked    <= 1'b1;
                        end
                    end
                    TRACK: begin
                        lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[0]};
                        if (idx == 4'd14) begin
                            idx       <= '0;
                            mcnt      <= '0;
                            bit_valid <= 1'b1;
                            bit_out   <= (m_track < 4'd8);
                            corr      <= m_track;
                            if (!track_amb) begin
                                miss <= '0;
                            end else if (miss + 8'd1 == 8'(MISS_MAX)) begin
                                state  <= SEARCH;
                                locked <= 1'b0;
                                fill   <= '0;
                                window <= '0;
                                miss   <= '0;
                            end else begin
                                miss <= miss + 8'd1;
                            end
                        end else begin
                            idx  <= idx + 4'd1;
                            mcnt <= m_track;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule
